// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//
// Owns the single register-file write port at the end of the 16-bit
// pipeline. In-order pipeline write-back results compete with results
// from the long-latency multicycle unit (mul/div). Multicycle results
// are buffered in a small FIFO. The FIFO head wins the port when the
// FIFO is full or when the head has waited AGE_MAX cycles; otherwise
// the pipeline has priority. A HALT token starts a drain: the pipeline
// is frozen, the FIFO empties, and `halted` rises once the multicycle
// unit is idle and every outstanding write has retired.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   pipe_valid/rd/data         pipeline write-back request
//   pipe_halt                  HALT token from pipeline write-back
//   pipe_stall                 pipeline request not accepted; hold inputs
//   mc_valid/rd/data           multicycle result offered to the FIFO
//   mc_ready                   FIFO accepts a multicycle result
//   mc_busy                    multicycle unit has an operation in flight
//   rf_we/rf_rd/rf_wdata       registered register-file write port
//   halted                     sticky: halted with all writes retired
module wb_port_arbiter #(
  parameter int DATA_W    = 16,
  parameter int REG_W     = 4,
  parameter int BUF_DEPTH = 2,
  parameter int AGE_MAX   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_valid,
  input  logic [REG_W-1:0]  pipe_rd,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              pipe_halt,
  output logic              pipe_stall,
  input  logic              mc_valid,
  input  logic [REG_W-1:0]  mc_rd,
  input  logic [DATA_W-1:0] mc_data,
  output logic              mc_ready,
  input  logic              mc_busy,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_rd,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              halted
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int AGE_W = $clog2(AGE_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);
  localparam logic [AGE_W-1:0] AGE_LIM  = AGE_W'(AGE_MAX);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Saturating increment for the head-of-FIFO wait counter.
  function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
    return (a == AGE_LIM) ? a : a + AGE_W'(1);
  endfunction

  state_t state;
  state_t state_nxt;

  // FIFO storage (data only, never reset) and its control state.
  logic [REG_W-1:0]  buf_rd   [BUF_DEPTH];
  logic [DATA_W-1:0] buf_data [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [AGE_W-1:0]  age;

  logic              fifo_full;
  logic              fifo_empty;
  logic              age_out;
  logic              push;
  logic              pop;

  logic              grant_fifo;
  logic              grant_pipe;
  logic              stall_int;

  logic              vld_p0;
  logic              we_p0;
  logic [REG_W-1:0]  rd_p0;
  logic [DATA_W-1:0] data_p0;

  // ---- Stage p0: FIFO status, grant decision, write selection ----

  assign fifo_full  = (count == CNT_FULL);
  assign fifo_empty = (count == '0);
  assign age_out    = !fifo_empty && (age == AGE_LIM);

  // Outputs are forced quiet while reset is held so upstream neither
  // pushes into nor waits on a block that is being cleared.
  assign mc_ready   = !rst && !fifo_full && (state != ST_HALTED);
  assign pipe_stall = !rst && stall_int;

  assign push = mc_valid && mc_ready;
  assign pop  = grant_fifo;

  always_comb begin
    state_nxt  = state;
    grant_fifo = 1'b0;
    grant_pipe = 1'b0;
    stall_int  = 1'b0;
    case (state)
      ST_RUN: begin
        if (fifo_full || age_out) begin
          // Forced drain of the FIFO head: the pipeline must wait,
          // including a HALT token, which is taken on a later cycle.
          grant_fifo = 1'b1;
          stall_int  = pipe_valid || pipe_halt;
        end else if (pipe_valid) begin
          grant_pipe = 1'b1;
        end else if (!fifo_empty) begin
          grant_fifo = 1'b1;
        end
        if (pipe_halt && !stall_int) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        stall_int  = 1'b1;
        grant_fifo = !fifo_empty;
        // Only finish once nothing can still arrive from the mc unit.
        if (fifo_empty && !mc_busy && !mc_valid) begin
          state_nxt = ST_HALTED;
        end
      end
      ST_HALTED: begin
        stall_int = 1'b1;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  assign vld_p0  = grant_fifo || grant_pipe;
  assign rd_p0   = grant_fifo ? buf_rd[rd_ptr]   : pipe_rd;
  assign data_p0 = grant_fifo ? buf_data[rd_ptr] : pipe_data;
  // A granted write to R0 is consumed but never reaches the register file.
  assign we_p0   = vld_p0 && (rd_p0 != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      age    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // Age tracks how long the current head has been passed over;
      // a newly pushed entry behind it does not restart the count.
      if (pop) begin
        age <= '0;
      end else if (!fifo_empty) begin
        age <= age_sat_inc(age);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_rd[wr_ptr]   <= mc_rd;
      buf_data[wr_ptr] <= mc_data;
    end
  end

  // ---- Stage p1: registered register-file write port ----

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= we_p0;
      if (vld_p0) begin
        rf_rd    <= rd_p0;
        rf_wdata <= data_p0;
      end
    end
  end

  // The HALTED state is entered the cycle after the drain condition,
  // so the final write has already been presented on rf_we.
  assign halted = (state == ST_HALTED);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed scenarios plus randomized
// traffic, checked by a scoreboard against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int DATA_W    = 16;
  localparam int REG_W     = 4;
  localparam int BUF_DEPTH = 2;
  localparam int AGE_MAX   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              pipe_valid;
  logic [REG_W-1:0]  pipe_rd;
  logic [DATA_W-1:0] pipe_data;
  logic              pipe_halt;
  logic              pipe_stall;
  logic              mc_valid;
  logic [REG_W-1:0]  mc_rd;
  logic [DATA_W-1:0] mc_data;
  logic              mc_ready;
  logic              mc_busy;
  logic              rf_we;
  logic [REG_W-1:0]  rf_rd;
  logic [DATA_W-1:0] rf_wdata;
  logic              halted;

  wb_port_arbiter #(
    .DATA_W(DATA_W), .REG_W(REG_W), .BUF_DEPTH(BUF_DEPTH), .AGE_MAX(AGE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .pipe_halt(pipe_halt), .pipe_stall(pipe_stall),
    .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data),
    .mc_ready(mc_ready), .mc_busy(mc_busy),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  typedef struct {
    int                cyc;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } exp_t;

  // Reference model state: buffered mc results, head wait time, phase flags.
  ent_t fifo_q[$];
  exp_t exp_q[$];
  int   m_age;
  bit   m_drain;
  bit   m_halt;
  bit   halted_exp;
  bit   exp_stall;
  bit   exp_ready;
  bit   chk_en;
  bit   done;
  int   cyc;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t mon_e;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) halted_exp <= 1'b0;
    else     halted_exp <= m_halt;
  end

  // One cycle of the arbitration rules applied to the current inputs.
  task automatic eval_model();
    int   n;
    bit   g_fifo;
    bit   g_pipe;
    bit   st;
    bit   rdy;
    ent_t h;
    exp_t e;
    n      = fifo_q.size();
    g_fifo = 1'b0;
    g_pipe = 1'b0;
    st     = 1'b0;
    rdy    = !m_halt && (n < BUF_DEPTH);
    if (m_halt) begin
      st = 1'b1;
    end else if (m_drain) begin
      st     = 1'b1;
      g_fifo = (n > 0);
    end else if (n == BUF_DEPTH || (n > 0 && m_age >= AGE_MAX)) begin
      g_fifo = 1'b1;
      st     = pipe_valid || pipe_halt;
    end else if (pipe_valid) begin
      g_pipe = 1'b1;
    end else if (n > 0) begin
      g_fifo = 1'b1;
    end
    exp_stall = st;
    exp_ready = rdy;
    if (g_pipe && pipe_rd != '0) begin
      e.cyc = cyc + 1; e.rd = pipe_rd; e.data = pipe_data;
      exp_q.push_back(e);
    end
    if (g_fifo) begin
      h = fifo_q.pop_front();
      if (h.rd != '0) begin
        e.cyc = cyc + 1; e.rd = h.rd; e.data = h.data;
        exp_q.push_back(e);
      end
      m_age = 0;
    end else if (n > 0 && m_age < AGE_MAX) begin
      m_age++;
    end
    if (mc_valid && rdy) begin
      h.rd = mc_rd; h.data = mc_data;
      fifo_q.push_back(h);
    end
    if (!m_drain && !m_halt && pipe_halt && !st) begin
      m_drain = 1'b1;
    end else if (m_drain && n == 0 && !mc_busy && !mc_valid) begin
      m_drain = 1'b0;
      m_halt  = 1'b1;
    end
  endtask

  task automatic drive_idle();
    pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0; pipe_halt = 1'b0;
    mc_valid = 1'b0; mc_rd = '0; mc_data = '0; mc_busy = 1'b0;
  endtask

  // Called 2 time units after a rising edge; returns at the same point
  // of the following cycle.
  task automatic step(input logic pv, input logic [REG_W-1:0] prd,
                      input logic [DATA_W-1:0] pd, input logic ph,
                      input logic mv, input logic [REG_W-1:0] mrd,
                      input logic [DATA_W-1:0] md, input logic mb);
    pipe_valid = pv; pipe_rd = prd; pipe_data = pd; pipe_halt = ph;
    mc_valid = mv; mc_rd = mrd; mc_data = md; mc_busy = mb;
    #1;
    eval_model();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    fifo_q.delete();
    exp_q.delete();
    m_age   = 0;
    m_drain = 1'b0;
    m_halt  = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor / scoreboard: samples on the falling edge.
  always @(negedge clk) begin
    if (done) begin
      chk("pending_writes", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end else if (rst) begin
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_rf_rd", 32'(rf_rd), 32'd0);
      chk("rst_rf_wdata", 32'(rf_wdata), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_pipe_stall", 32'(pipe_stall), 32'd0);
      chk("rst_mc_ready", 32'(mc_ready), 32'd0);
    end else if (chk_en) begin
      chk("pipe_stall", 32'(pipe_stall), 32'(exp_stall));
      chk("mc_ready", 32'(mc_ready), 32'(exp_ready));
      chk("halted", 32'(halted), 32'(halted_exp));
      if (rf_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got rd=%0d data=%0h, expected no write (cycle %0d)",
                   rf_rd, rf_wdata, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("write_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("write_rd", 32'(rf_rd), 32'(mon_e.rd));
          chk("write_data", 32'(rf_wdata), 32'(mon_e.data));
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        mon_e = exp_q.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL missing_write: got rf_we=%0b, expected rd=%0d data=%0h (cycle %0d)",
                 rf_we, mon_e.rd, mon_e.data, cyc);
      end
    end
  end

  initial begin
    logic              pv;
    logic              mv;
    logic              mb;
    logic [REG_W-1:0]  prd;
    logic [REG_W-1:0]  mrd;
    logic [DATA_W-1:0] pd;
    logic [DATA_W-1:0] md;

    rst = 1'b0;
    chk_en = 1'b0;
    done = 1'b0;
    m_age = 0;
    m_drain = 1'b0;
    m_halt = 1'b0;
    exp_stall = 1'b0;
    exp_ready = 1'b0;
    drive_idle();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    chk_en = 1'b1;

    // Pipeline write only.
    step(1'b1, 4'd3, 16'h1234, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    idle(2);

    // Multicycle write only.
    step(1'b0, 4'd0, 16'h0, 1'b0, 1'b1, 4'd5, 16'hBEEF, 1'b0);
    idle(3);

    // FIFO fills while the pipeline streams writes.
    prd = 4'd1;
    for (int i = 0; i < 12; i++) begin
      mv  = (i < 2);
      mrd = (i == 0) ? 4'd6 : 4'd7;
      md  = (i == 0) ? 16'h0006 : 16'h0007;
      step(1'b1, prd, {12'h100, prd}, 1'b0, mv, mrd, md, 1'b1);
      if (!exp_stall) prd = (prd == 4'd15) ? 4'd1 : prd + 4'd1;
    end
    idle(4);

    // Single entry starved by continuous pipeline traffic.
    prd = 4'd1;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, prd, {12'h200, prd}, 1'b0, (i == 0), 4'd9, 16'h0999, 1'b0);
      if (!exp_stall) prd = (prd == 4'd15) ? 4'd1 : prd + 4'd1;
    end
    idle(4);

    // Writes to R0 are consumed without a register-file write.
    step(1'b1, 4'd0, 16'hFFFF, 1'b0, 1'b1, 4'd0, 16'hABCD, 1'b0);
    idle(3);

    // Randomized traffic; stalled or unaccepted requests are held.
    pv = 1'b0; mv = 1'b0; prd = '0; pd = '0; mrd = '0; md = '0;
    for (int i = 0; i < 600; i++) begin
      if (!(pv && exp_stall)) begin
        pv  = ($urandom_range(0, 9) < 6);
        prd = 4'($urandom_range(0, 15));
        pd  = 16'($urandom);
      end
      if (!(mv && !exp_ready)) begin
        mv  = ($urandom_range(0, 9) < 4);
        mrd = 4'($urandom_range(0, 15));
        md  = 16'($urandom);
      end
      mb = 1'($urandom_range(0, 1));
      step(pv, prd, pd, 1'b0, mv, mrd, md, mb);
    end
    idle(4);

    // Halt drain with a buffered entry and a late multicycle result.
    step(1'b1, 4'd1, 16'h0111, 1'b0, 1'b1, 4'd2, 16'h0022, 1'b1);
    step(1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 4'd0, 16'h0, 1'b1);
    step(1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 4'd0, 16'h0, 1'b1);
    step(1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 4'd0, 16'h0, 1'b1);
    step(1'b0, 4'd0, 16'h0, 1'b1, 1'b1, 4'd4, 16'h0044, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 4'd0, 16'h0, 1'b0);
    end
    // Once halted nothing is accepted.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'd5, 16'h5555, 1'b1, 1'b1, 4'd6, 16'h6666, 1'b0);
    end

    // Reset while draining with an entry still buffered.
    do_reset();
    step(1'b1, 4'd1, 16'h0101, 1'b0, 1'b1, 4'd3, 16'h0303, 1'b1);
    step(1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 4'd0, 16'h0, 1'b1);
    step(1'b0, 4'd0, 16'h0, 1'b1, 1'b1, 4'd8, 16'h0808, 1'b1);
    do_reset();
    idle(3);

    // Normal operation resumes after reset.
    step(1'b1, 4'd10, 16'h0A0A, 1'b0, 1'b1, 4'd11, 16'h0B0B, 1'b0);
    step(1'b1, 4'd12, 16'h0C0C, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    idle(6);

    done = 1'b1;
  end

endmodule
